sram_1k_ctl: RTL
================

Name: sram_1k_ctl

Overview:
- Sequencer and two-port arbiter for a 1K x W word memory built from W parallel 1Kx1 static RAM parts that share address, chip-enable and write-enable.
- Generates glitch-free registered CE_N/WE_N strobes with setup, pulse and hold phases.
- Latches read data and returns it to the winning requester with a one-cycle ack.
- Sits between the processor-side memory port (A) and the console/debug port (B) and the RAM bank.

Parameters:
- W, 32, data width = number of 1Kx1 parts in the bank
- READ_WAIT, 2, cycles CE_N held low before read data is captured (1..15)
- WE_PULSE, 2, cycles WE_N held low during a write (1..15)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- a_req  input  1  port A request, held until a_ack
- a_we  input  1  port A write (1) / read (0)
- a_addr  input  10  port A word address
- a_wdata  input  W  port A write data
- a_ack  output  1  one-cycle completion pulse to A
- a_rdata  output  W  read data to A, valid with a_ack, held until next A read
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as A, for port B
- ram_addr  output  10  address to all parts
- ram_di  output  W  write data to the parts
- ram_do  input  W  read data from the parts
- ram_ce_n  output  1  chip enable, active low
- ram_we_n  output  1  write enable, active low
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, immediate): ram_ce_n=1, ram_we_n=1, ram_addr=0, ram_di=0, a_ack=b_ack=0, a_rdata=b_rdata=0, state=IDLE, last_grant=B.
- Reset mid-operation aborts at once with strobes forced high. Contents of the word being written are undefined.
- All RAM outputs are registered. ram_addr and ram_di are loaded once at grant and stay stable for the whole operation.
- States: IDLE, RD, WSU, WP, WH, ACK.
- IDLE:
  - No request: stay in IDLE with ce_n=1 and we_n=1.
  - One request: grant that port.
  - Both requesting: round-robin, grant the port not granted last. After reset A wins first.
  - Grant cycle (cycle 0): latch addr, wdata, we and the granted-port id; update last_grant.
  - Next state is RD if we=0, otherwise WSU.
- RD: ce_n=0, we_n=1 for READ_WAIT cycles (cycles 1..READ_WAIT). On the last RD cycle, ram_do is captured into the granted port's rdata.
- WSU: 1 cycle, ce_n=0, we_n=1.
- WP: WE_PULSE cycles, ce_n=0, we_n=0.
- WH: 1 cycle, ce_n=0, we_n=1.
- ACK:
  - 1 cycle, ce_n=1, we_n=1; the granted port's ack=1 and the other ack stays 0.
  - Next state IDLE.
- Latency, counted from the IDLE sample cycle:
  - Read ack at cycle READ_WAIT+1 (default 3).
  - Write ack at cycle WE_PULSE+3 (default 5).
  - Minimum IDLE gap between operations is 1 cycle.
- Handshake:
  - The requester holds req, we, addr and wdata stable until it sees ack.
  - req sampled high in the cycle after ack is a new request.
  - Requests arriving while busy wait; they are never dropped.
- rdata of the non-granted port is unchanged. Writes never modify rdata.
- Internal cycle counter is 4 bits. Parameter values outside 1..15 are illegal.
- Address range is the full 0..1023; no wrap logic is needed.

Optional Feature:
- Macro SRAM_CLEAR_EN.
- Defined:
  - After reset release, the controller enters CLR and writes 0 to addresses 0..1023 in ascending order.
  - Each clear write uses the normal WSU/WP/WH sequence with no ACK cycle, so each takes WE_PULSE+2 cycles.
  - busy=1 throughout; requests are held off with no ack.
  - After address 1023 completes, the controller enters IDLE.
  - Total clear time is 1024*(WE_PULSE+2) cycles.
  - Reset during the clear restarts it from address 0.
- Not defined: the controller enters IDLE directly after reset and RAM contents are unknown.

Test Plan:
- Reset then A write addr 0x155 data 0xDEADBEEF -> ce_n low cycles 1-4, we_n low cycles 2-3, a_ack at cycle 5, b_ack stays 0.
- A read addr 0x155 with ram model -> ce_n low cycles 1-2, a_ack at cycle 3, a_rdata=0xDEADBEEF, b_rdata unchanged.
- a_req and b_req asserted together, both held for repeated reads -> grants alternate A,B,A,B; each ack is exactly 1 cycle wide.
- B write issued while A read is in progress -> b_req waits; B's WSU begins 2 cycles after a_ack, with one IDLE grant cycle in between.
- reset_n pulled low during WP -> ram_we_n and ram_ce_n go high asynchronously, busy=0, no ack; next request proceeds normally.
- With SRAM_CLEAR_EN: release reset, hold a_req -> busy high for 4096 cycles, every address 0..1023 reads back 0, a_ack follows only after the clear.

Source files
------------

// File: rtl/sram_1k_ctl.sv
// sram_1k_ctl
//   Sequencer and round-robin two-port arbiter for a 1K x W word memory built
//   from W parallel 1Kx1 static RAM parts sharing address, CE_N and WE_N.
//   All RAM-side outputs are registered. Strobes are decoded from the next
//   state, so they change only on clock edges and line up with the state.
//
// Parameters
//   W          data width (number of 1Kx1 parts)
//   READ_WAIT  cycles CE_N is low before read data is captured (1..15)
//   WE_PULSE   cycles WE_N is low during a write (1..15)
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata    port A request (held until a_ack)
//   a_ack/a_rdata                port A one-cycle ack, read data
//   b_*                          same as A, for port B
//   ram_addr/ram_di/ram_do       RAM bank address, write data, read data
//   ram_ce_n/ram_we_n            RAM chip enable / write enable, active low
//   busy                         high whenever the sequencer is not idle
//
// Optional build macro
//   SRAM_CLEAR_EN  after reset release, write 0 to every address 0..1023
//                  before accepting requests.

module sram_1k_ctl #(
    parameter int unsigned W         = 32,
    parameter int unsigned READ_WAIT = 2,
    parameter int unsigned WE_PULSE  = 2
) (
    input  logic         clk,
    input  logic         reset_n,

    input  logic         a_req,
    input  logic         a_we,
    input  logic [9:0]   a_addr,
    input  logic [W-1:0] a_wdata,
    output logic         a_ack,
    output logic [W-1:0] a_rdata,

    input  logic         b_req,
    input  logic         b_we,
    input  logic [9:0]   b_addr,
    input  logic [W-1:0] b_wdata,
    output logic         b_ack,
    output logic [W-1:0] b_rdata,

    output logic [9:0]   ram_addr,
    output logic [W-1:0] ram_di,
    input  logic [W-1:0] ram_do,
    output logic         ram_ce_n,
    output logic         ram_we_n,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WSU,
        WP,
        WH,
        ACK,
        CLR
    } state_t;

    localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);
    localparam logic [3:0] WP_LOAD = 4'(WE_PULSE - 1);

`ifdef SRAM_CLEAR_EN
    localparam state_t RESET_STATE = CLR;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;
    logic       gnt_b;         // port owning the current operation: 0=A, 1=B
    logic       last_grant_b;  // port granted most recently: 0=A, 1=B
    logic       clr_active;

    logic       any_req;
    logic       pick_b;
    logic       sel_we;

    // With both ports requesting, the port not granted last wins.
    assign any_req = a_req | b_req;
    assign pick_b  = b_req & (~a_req | ~last_grant_b);
    assign sel_we  = pick_b ? b_we : a_we;

    assign busy = (state != IDLE);

`ifdef SRAM_CLEAR_EN
    // CLR is the setup phase of each clear write and takes the place of WSU,
    // so one clear word costs exactly WE_PULSE+2 cycles with no grant cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_active <= 1'b1;
        end else if (state == WH && ram_addr == 10'h3FF) begin
            clr_active <= 1'b0;
        end
    end
`else
    assign clr_active = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = sel_we ? WSU : RD;
                    cnt_nx   = RD_LOAD;
                end
            end
            RD: begin
                if (cnt == '0) begin
                    state_nx = ACK;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            WSU, CLR: begin
                state_nx = WP;
                cnt_nx   = WP_LOAD;
            end
            WP: begin
                if (cnt == '0) begin
                    state_nx = WH;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            WH: begin
                if (!clr_active) begin
                    state_nx = ACK;
                end else if (ram_addr == 10'h3FF) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = CLR;
                end
            end
            ACK: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RESET_STATE;
            cnt          <= '0;
            ram_ce_n     <= 1'b1;
            ram_we_n     <= 1'b1;
            ram_addr     <= '0;
            ram_di       <= '0;
            a_ack        <= 1'b0;
            b_ack        <= 1'b0;
            a_rdata      <= '0;
            b_rdata      <= '0;
            gnt_b        <= 1'b0;
            last_grant_b <= 1'b1;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            // Strobes follow the state being entered, so they are glitch-free
            // flops aligned with the phase they belong to.
            ram_ce_n <= !(state_nx inside {RD, WSU, WP, WH, CLR});
            ram_we_n <= (state_nx != WP);
            a_ack    <= (state_nx == ACK) && !gnt_b;
            b_ack    <= (state_nx == ACK) && gnt_b;

            if (state == IDLE && any_req) begin
                ram_addr     <= pick_b ? b_addr : a_addr;
                ram_di       <= pick_b ? b_wdata : a_wdata;
                gnt_b        <= pick_b;
                last_grant_b <= pick_b;
            end

            if (state == WH && state_nx == CLR) begin
                ram_addr <= ram_addr + 10'd1;
            end

            if (state == RD && cnt == '0) begin
                if (gnt_b) begin
                    b_rdata <= ram_do;
                end else begin
                    a_rdata <= ram_do;
                end
            end
        end
    end

endmodule
